// File: rtl/inv_chain_meter.sv
// Gated edge-count frequency meter for up to eight ring-oscillator channels.
// A start pulse arms one gate window of 2^WIN_W clocks; the count lands in a byte-readable result.
module inv_chain_meter #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [NCH-1:0]   osc_in,
    input  logic [7:0]       ui_in,
    output logic [7:0]       uo_out,
    input  logic [7:0]       uio_in,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe
);

    typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_LAST = {WIN_W{1'b1}};

    state_t             state_q, state_d;
    logic [NCH-1:0]     osc_meta_q, osc_meta_d;
    logic [NCH-1:0]     osc_sync_q, osc_sync_d;
    logic [NCH-1:0]     osc_prev_q, osc_prev_d;
    logic [6:0]         ui_meta_q, ui_meta_d;
    logic [6:0]         ui_sync_q, ui_sync_d;
    logic               start_prev_q, start_prev_d;
    logic [2:0]         ch_q, ch_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               ovf_q, ovf_d;
    logic               ovf_out_q, ovf_out_d;
    logic               done_q, done_d;

    logic [7:0]         edge_vec;
    logic               start_req;
    logic               busy;
    logic [31:0]        result_ext;
    logic               unused_inputs;

    // Channels above NCH read as never toggling so the 3-bit select can index directly.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_edge
            if (gi < NCH) begin : g_live
                assign edge_vec[gi] = osc_sync_q[gi] & ~osc_prev_q[gi];
            end else begin : g_pad
                assign edge_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign start_req = ui_sync_q[3] & ~start_prev_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        osc_meta_d   = osc_in;
        osc_sync_d   = osc_meta_q;
        osc_prev_d   = osc_sync_q;
        ui_meta_d    = ui_in[6:0];
        ui_sync_d    = ui_meta_q;
        start_prev_d = ui_sync_q[3];
        state_d      = state_q;
        ch_d         = ch_q;
        edge_cnt_d   = edge_cnt_q;
        win_cnt_d    = win_cnt_q;
        ovf_d        = ovf_q;
        ovf_out_d    = ovf_out_q;
        result_d     = result_q;
        done_d       = done_q;

        case (state_q)
            IDLE: begin
                if (start_req) state_d = ARM;
            end
            ARM: begin
                edge_cnt_d = '0;
                win_cnt_d  = '0;
                ovf_d      = 1'b0;
                ch_d       = (int'(ui_sync_q[2:0]) < NCH) ? ui_sync_q[2:0] : 3'd0;
                state_d    = GATE;
            end
            GATE: begin
                if (edge_vec[ch_q]) begin
                    if (edge_cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
                win_cnt_d = win_cnt_q + WIN_W'(1);
                // The final gate cycle's edge is folded in so the window is exactly 2^WIN_W long.
                if (win_cnt_q == WIN_LAST) begin
                    state_d   = LATCH;
                    result_d  = edge_cnt_d;
                    ovf_out_d = ovf_d;
                    done_d    = 1'b1;
                end
            end
            LATCH: begin
                state_d = ui_sync_q[4] ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!ena) begin
            state_d   = IDLE;
            result_d  = result_q;
            ovf_out_d = ovf_out_q;
            done_d    = done_q;
        end

        if (state_d == ARM) done_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            osc_meta_q   <= '0;
            osc_sync_q   <= '0;
            osc_prev_q   <= '0;
            ui_meta_q    <= '0;
            ui_sync_q    <= '0;
            start_prev_q <= 1'b0;
            ch_q         <= '0;
            edge_cnt_q   <= '0;
            result_q     <= '0;
            win_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            ovf_out_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            osc_meta_q   <= osc_meta_d;
            osc_sync_q   <= osc_sync_d;
            osc_prev_q   <= osc_prev_d;
            ui_meta_q    <= ui_meta_d;
            ui_sync_q    <= ui_sync_d;
            start_prev_q <= start_prev_d;
            ch_q         <= ch_d;
            edge_cnt_q   <= edge_cnt_d;
            result_q     <= result_d;
            win_cnt_q    <= win_cnt_d;
            ovf_q        <= ovf_d;
            ovf_out_q    <= ovf_out_d;
            done_q       <= done_d;
        end
    end

    assign result_ext = 32'(result_q);
    assign uo_out     = result_ext[{ui_sync_q[6:5], 3'b000} +: 8];
    assign uio_out    = {5'b00000, ovf_out_q, done_q, busy};
    assign uio_oe     = 8'h07;

    assign unused_inputs = ^{uio_in, ui_in[7]};

endmodule

// File: doc/inv_chain_meter.md
INV_CHAIN_METER -- requirements
Module: inv_chain_meter

Interface
REQ-001 Parameter NCH, default 4, number of oscillator/inverter-chain channels; legal range 1..8.
REQ-002 Parameter CNT_W, default 16, edge-counter and result width; legal range 8..24.
REQ-003 Parameter WIN_W, default 10, gate window length of 2^WIN_W clk cycles; legal range 4..20.
REQ-004 clk  input  1  single clock; all state SHALL be clocked on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  design enable; low forces the FSM to IDLE on the next edge, result registers held.
REQ-007 osc_in  input  NCH  asynchronous oscillator outputs from the inverter chains.
REQ-008 ui_in  input  8  [2:0] channel select, [3] start, [4] continuous mode, [6:5] readout byte select, [7] unused.
REQ-009 uo_out  output  8  selected result byte.
REQ-010 uio_in  input  8  unused.
REQ-011 uio_out  output  8  [0] busy, [1] done, [2] overflow, [7:3] constant 0.
REQ-012 uio_oe  output  8  constant 8'h07.

Function
REQ-013 Each osc_in bit SHALL pass through a 2-flop synchronizer; a rising edge is a synchronized 0->1 transition between consecutive cycles.
REQ-014 ui_in[4:0] SHALL be 2-flop synchronized; start is a synchronized 0->1 transition of ui_in[3].
REQ-015 FSM states: IDLE, ARM, GATE, LATCH.
REQ-016 IDLE -> ARM on start; otherwise remain in IDLE.
REQ-017 ARM (1 cycle): clear edge counter, window counter and overflow; capture channel select; -> GATE.
REQ-018 Channel select >= NCH SHALL capture channel 0.
REQ-019 GATE: count rising edges of the captured channel for exactly 2^WIN_W cycles, then -> LATCH.
REQ-020 Edge counter SHALL saturate at 2^CNT_W-1 and set the overflow flag; it never wraps.
REQ-021 LATCH (1 cycle): copy edge counter to result, set done, update uio_out[2]; -> ARM if continuous mode is set, else -> IDLE.
REQ-022 busy = 1 in ARM, GATE and LATCH; 0 in IDLE.
REQ-023 done SHALL clear on entry to ARM and set in LATCH; it stays set through IDLE.
REQ-024 Start while busy SHALL be ignored; channel-select changes during GATE SHALL be ignored.
REQ-025 Clearing continuous mode during GATE SHALL complete the current measurement, then -> IDLE.
REQ-026 uo_out = result bits [8*b+7 : 8*b] for b = ui_in[6:5] (synchronized), combinationally from the result register; bits at or above CNT_W read 0.
REQ-027 The result register SHALL change only in LATCH; it is stable during a new GATE.
REQ-028 ena low during GATE SHALL abort the measurement: FSM -> IDLE, result and done unchanged, busy cleared.

Reset
REQ-029 rst_n low SHALL asynchronously force: FSM IDLE, all synchronizers 0, counters 0, result 0, done 0, overflow 0.
REQ-030 Output values during reset: uo_out = 0, uio_out = 0, uio_oe = 8'h07.
REQ-031 Reset asserted mid-GATE SHALL discard the measurement; the first start after release begins a fresh ARM.
REQ-032 osc_in activity during or just after reset SHALL NOT produce a count outside GATE.

Verification
REQ-033 Default params; osc_in[1] square wave with period 8 clk; sel = 1; start pulse -> busy for 1+1024+1 cycles; result 128; done = 1; overflow = 0; bytes 0/1 read 8'h80/8'h00.
REQ-034 CNT_W = 8; osc_in[0] with period 2 clk; start -> result 255, overflow = 1, uo_out = 8'hFF for byte 0, 8'h00 for bytes 1..3.
REQ-035 Continuous mode set; osc period 4 -> repeated LATCH every 1026 cycles, each result 256; clear mode mid-GATE -> one more result, then IDLE, busy = 0.
REQ-036 Start re-pulsed mid-GATE and sel changed from 1 to 2 -> ignored, measurement completes on channel 1 with unchanged length.
REQ-037 ena dropped mid-GATE -> IDLE next cycle, busy = 0, previous result and done retained; rst_n pulse mid-GATE -> all outputs 0, uio_oe = 8'h07.
REQ-038 sel = 7 with NCH = 4 -> channel 0 measured.
